// File: rtl/clk_rate_pkg.sv
// Shared types for the clock-rate controller.
// State encoding and default counter width.
package clk_rate_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PEND,
        STOPPING
    } state_e;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter with clear/increment.
// Flags the last cycle of a half-period.
module half_period_counter
    import clk_rate_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] period,
    output logic             term
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // clear has priority; otherwise advance when asked
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + ONE;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign term = (count_q == (period - ONE));

endmodule

// File: rtl/clk_rate_controller.sv
// Run-time controller for the divided clock.
// Applies new half-periods only at boundaries.
module clk_rate_controller
    import clk_rate_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int DEFAULT_PERIOD = 1
) (
    input  logic             initial_clk,
    input  logic             reset,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk,
    output logic             tick,
    output logic [CNT_W-1:0] cur_period,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    state_e           state_q, state_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;

    logic             term;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             acc;
    logic             acc_ok;

    half_period_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (initial_clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .inc    (cnt_inc),
        .period (cur_q),
        .term   (term)
    );

    // ready unless a value is already waiting for a boundary
    assign cfg_ready = (state_q == IDLE) || (state_q == RUN) ||
                       ((state_q == STOPPING) && !pend_vld_q);
    assign acc       = cfg_valid && cfg_ready;
    assign acc_ok    = acc && (cfg_period != '0);

    // next-state, divided clock, pending slot and period update
    always_comb begin
        state_d    = state_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        err_d      = acc && (cfg_period == '0);
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        if (state_q == IDLE) begin
            cnt_clr = 1'b1;
            clk_d   = 1'b0;
            if (acc_ok) cur_d = cfg_period;
            if (run) state_d = RUN;
        end else if (!run && !clk_q) begin
            // already low: stop at once, flush any pending value
            cnt_clr    = 1'b1;
            state_d    = IDLE;
            pend_vld_d = 1'b0;
            if (acc_ok) begin
                cur_d = cfg_period;
            end else if (pend_vld_q) begin
                cur_d = pend_q;
            end
        end else if (term) begin
            cnt_clr = 1'b1;
            clk_d   = ~clk_q;
            tick_d  = 1'b1;
            if (!run) begin
                // clk was high, this edge parks it low
                state_d    = IDLE;
                pend_vld_d = 1'b0;
                if (acc_ok) begin
                    cur_d = cfg_period;
                end else if (pend_vld_q) begin
                    cur_d = pend_q;
                end
            end else if (pend_vld_q) begin
                cur_d      = pend_q;
                pend_vld_d = 1'b0;
                state_d    = RUN;
            end else if (acc_ok) begin
                // toggle uses old period, new one waits a boundary
                pend_d     = cfg_period;
                pend_vld_d = 1'b1;
                state_d    = PEND;
            end else begin
                state_d = RUN;
            end
        end else begin
            cnt_inc = 1'b1;
            if (acc_ok) begin
                pend_d     = cfg_period;
                pend_vld_d = 1'b1;
            end
            if (!run) begin
                state_d = STOPPING;
            end else if (acc_ok || pend_vld_q) begin
                state_d = PEND;
            end else begin
                state_d = RUN;
            end
        end
    end

    // state and registered outputs
    always_ff @(posedge initial_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            cur_q      <= DEF_P;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            err_q      <= err_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign clk        = clk_q;
    assign tick       = tick_q;
    assign cfg_err    = err_q;
    assign cur_period = cur_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_clk_rate_controller.sv
// Bench for clk_rate_controller: directed steps
// plus random traffic against a cycle model.
module tb_clk_rate_controller;

    localparam int W   = 8;
    localparam int DEF = 1;

    logic         initial_clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_period = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk;
    logic         tick;
    logic [W-1:0] cur_period;
    logic         busy;

    int total = 0;
    int bad   = 0;

    // model: generating flag, divided clock, cycles into the
    // current half-period, half-period, waiting value (-1 none)
    bit m_on, m_clk, m_tick, m_err, m_init;
    int m_pos, m_P, m_pend;

    always #5 initial_clk = ~initial_clk;

    clk_rate_controller #(
        .CNT_W          (W),
        .DEFAULT_PERIOD (DEF)
    ) dut (
        .initial_clk (initial_clk),
        .reset       (reset),
        .run         (run),
        .cfg_valid   (cfg_valid),
        .cfg_period  (cfg_period),
        .cfg_ready   (cfg_ready),
        .cfg_err     (cfg_err),
        .clk         (clk),
        .tick        (tick),
        .cur_period  (cur_period),
        .busy        (busy)
    );

    function automatic bit m_ready();
        return !m_on || (m_pend < 0);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(bit r, bit v, int p, bit rst);
        bit acc, nv;
        m_tick = 0;
        m_err  = 0;
        if (rst) begin
            m_on = 0; m_clk = 0; m_pos = 0;
            m_P = DEF; m_pend = -1; m_init = 1;
            return;
        end
        acc   = v && m_ready();
        m_err = acc && (p == 0);
        nv    = acc && (p != 0);
        if (!m_on) begin
            if (nv) m_P = p;
            if (r) begin m_on = 1; m_pos = 0; end
        end else if (!r && !m_clk) begin
            m_on = 0; m_pos = 0;
            if (nv) m_P = p;
            else if (m_pend >= 0) m_P = m_pend;
            m_pend = -1;
        end else if (m_pos + 1 == m_P) begin
            m_clk = !m_clk; m_tick = 1; m_pos = 0;
            if (!r) begin
                m_on = 0;
                if (nv) m_P = p;
                else if (m_pend >= 0) m_P = m_pend;
                m_pend = -1;
            end else if (m_pend >= 0) begin
                m_P = m_pend; m_pend = -1;
            end else if (nv) begin
                m_pend = p;
            end
        end else begin
            m_pos++;
            if (nv) m_pend = p;
        end
    endtask

    task automatic cyc(bit r, bit v, int p, bit rst);
        @(negedge initial_clk);
        reset      = rst;
        run        = r;
        cfg_valid  = v;
        cfg_period = p[W-1:0];
        #1;
        if (!rst && m_init) chk("ready", cfg_ready, m_ready());
        step(r, v, p, rst);
        @(posedge initial_clk);
        #1;
        chk("clk", clk, m_clk);
        chk("tick", tick, m_tick);
        chk("cur_period", cur_period, m_P);
        chk("cfg_err", cfg_err, m_err);
        chk("busy", busy, m_on);
    endtask

    task automatic hold(bit r, int n);
        for (int i = 0; i < n; i++) cyc(r, 0, 0, 0);
    endtask

    initial begin
        int n;
        bit rr;
        m_init = 0;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("rst_curp", cur_period, DEF);
        chk("rst_ready", cfg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_clk", clk, 0);

        // P=1: rises one edge after run sampled, toggles every cycle
        cyc(1, 0, 0, 0);
        chk("p1_lat0", clk, 0);
        cyc(1, 0, 0, 0);
        chk("p1_rise", clk, 1);
        chk("p1_tick", tick, 1);
        cyc(1, 0, 0, 0);
        chk("p1_fall", clk, 0);
        hold(1, 5);
        hold(0, 3);

        // P=4 loaded in idle
        hold(0, 2);
        cyc(0, 1, 4, 0);
        chk("cfg4", cur_period, 4);
        cyc(1, 0, 0, 0);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 0, 0);
            n += int'(tick);
        end
        chk("p4_ticks", n, 4);

        // P=3 running, offer 5 mid half-period
        cyc(0, 0, 0, 1);
        cyc(0, 1, 3, 0);
        hold(1, 5);
        cyc(1, 1, 5, 0);
        chk("pend_ready", cfg_ready, 0);
        chk("pend_oldp", cur_period, 3);
        hold(1, 20);
        chk("pend_newp", cur_period, 5);

        // zero period is rejected with an error pulse
        cyc(1, 1, 0, 0);
        chk("err_pulse", cfg_err, 1);
        cyc(1, 0, 0, 0);
        chk("err_once", cfg_err, 0);
        chk("err_keep", cur_period, 5);
        hold(1, 8);

        // stop while high with P=4
        cyc(1, 1, 4, 0);
        for (int i = 0; i < 30 && m_pend >= 0; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 30 && !m_clk; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("stop_hi_busy", busy, 1);
        hold(0, 6);
        chk("stop_busy", busy, 0);
        chk("stop_clk", clk, 0);

        // stop while low goes idle on the next edge
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 30 && !m_clk; i++) cyc(1, 0, 0, 0);
        for (int i = 0; i < 30 && m_clk; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("stop_lo_busy", busy, 0);

        // reset while a value is pending
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 7, 0);
        chk("rp_ready", cfg_ready, 0);
        cyc(1, 0, 0, 1);
        chk("rp_clk", clk, 0);
        chk("rp_curp", cur_period, DEF);
        chk("rp_ready1", cfg_ready, 1);
        hold(1, 12);
        chk("rp_nopend", cur_period, DEF);

        // random traffic
        rr = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) rr = !rr;
            cyc(rr, $urandom_range(0, 3) == 0,
                int'($urandom_range(0, 7)),
                $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
